dmem_arbiter: RTL

- Two-requester arbiter that shares one data memory port between master 0 (core LSU) and master 1 (DMA/debug loader).
- The memory has a single request port, one-cycle registered read latency and a ready_i handshake.
- The arbiter grants one transaction at a time, forwards it to the memory, and returns read data/ready to the owner the following cycle.
- Default policy is round-robin.

---
 rtl/dmem_arbiter_if.sv | 51 +++++
 rtl/dmem_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
`timescale 1ns/1ps
// Bundle of the two master ports and the shared memory port around dmem_arbiter.
// The slave modport is the arbiter's view; the master modport is the masters-plus-memory view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              m0_req_i;
  logic              m0_we_i;
  logic [BE_W-1:0]   m0_be_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [DATA_W-1:0] m0_wdata_i;
  logic [DATA_W-1:0] m0_rdata_o;
  logic              m0_ready_o;

  logic              m1_req_i;
  logic              m1_we_i;
  logic [BE_W-1:0]   m1_be_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [DATA_W-1:0] m1_wdata_i;
  logic [DATA_W-1:0] m1_rdata_o;
  logic              m1_ready_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ready_i;

  modport slave (
    input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
    output m0_rdata_o, m0_ready_o,
    input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
    output m1_rdata_o, m1_ready_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_ready_i
  );

  modport master (
    output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
    input  m0_rdata_o, m0_ready_o,
    output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
    input  m1_rdata_o, m1_ready_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_ready_i
  );
endinterface

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter: shares one single-ported data memory between the core LSU (m0) and a DMA/debug loader (m1).
// Round-robin on ties by default; defining DMEM_ARB_FIXED_PRIO_EN makes m0 always win ties.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  dmem_arbiter_if.slave  bus
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   any_req, winner, accept;

  assign any_req = bus.m0_req_i | bus.m1_req_i;
  assign accept  = (state_q == IDLE) && any_req && bus.mem_ready_i;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign winner = ~bus.m0_req_i;
`else
  logic last_grant_q, last_grant_d;

  // On a tie the master that was not granted last goes first; a stalled grant does not rotate.
  assign winner       = (bus.m0_req_i & bus.m1_req_i) ? ~last_grant_q : bus.m1_req_i;
  assign last_grant_d = accept ? winner : last_grant_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    // NOTE: everything driven here gets a default first so no branch can infer a latch.
    state_d         = state_q;
    owner_d         = owner_q;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = {BE_W{1'b0}};
    bus.mem_addr_o  = {ADDR_W{1'b0}};
    bus.mem_wdata_o = {DATA_W{1'b0}};
    bus.m0_ready_o  = 1'b0;
    bus.m0_rdata_o  = {DATA_W{1'b0}};
    bus.m1_ready_o  = 1'b0;
    bus.m1_rdata_o  = {DATA_W{1'b0}};

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          bus.mem_req_o = 1'b1;
          if (winner) begin
            bus.mem_we_o    = bus.m1_we_i;
            bus.mem_be_o    = bus.m1_be_i;
            bus.mem_addr_o  = bus.m1_addr_i;
            bus.mem_wdata_o = bus.m1_wdata_i;
          end else begin
            bus.mem_we_o    = bus.m0_we_i;
            bus.mem_be_o    = bus.m0_be_i;
            bus.mem_addr_o  = bus.m0_addr_i;
            bus.mem_wdata_o = bus.m0_wdata_i;
          end
        end
        if (accept) begin
          state_d = RESP;
          owner_d = winner;
        end
      end
      RESP: begin
        // Memory data is forwarded for writes too; the owner ignores it.
        state_d = IDLE;
        if (owner_q) begin
          bus.m1_ready_o = 1'b1;
          bus.m1_rdata_o = bus.mem_rdata_i;
        end else begin
          bus.m0_ready_o = 1'b1;
          bus.m0_rdata_o = bus.mem_rdata_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A master must hold its request and payload steady until its ready pulse.
  m0_hold_a: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.m0_req_i && !bus.m0_ready_o |=> bus.m0_req_i &&
      $stable({bus.m0_we_i, bus.m0_be_i, bus.m0_addr_i, bus.m0_wdata_i}));

  m1_hold_a: assert property (@(posedge clk_i) disable iff (rst_i)
    bus.m1_req_i && !bus.m1_ready_o |=> bus.m1_req_i &&
      $stable({bus.m1_we_i, bus.m1_be_i, bus.m1_addr_i, bus.m1_wdata_i}));
endmodule
